// File: rtl/c_ldo_seq.sv
// LDO power sequencer: UVLO with hysteresis, on-delay, soft-start ramp,
// controlled discharge, short-circuit hiccup with limited retries and power-good.
module c_ldo_seq #(
  parameter int W        = 16,
  parameter int VOUT     = 500,
  parameter int PIN_MIN  = 100,
  parameter int PIN_HYS  = 10,
  parameter int BIAS_MIN = PIN_MIN,
  parameter int TON      = 100,
  parameter int TSS      = 100,
  parameter int TOFF     = 100,
  parameter int SCALE    = 16,
  parameter int DROP     = 20,
  parameter int PG_TH    = 450,
  parameter int TPG      = 4,
  parameter int TFLT     = 10,
  parameter int THIC     = 500,
  parameter int RETRY    = 3
) (
  input  logic                s_clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] pin,
  input  logic signed [W-1:0] bias,
  input  logic                sc,
  output logic signed [W-1:0] pout,
  output logic                pg,
  output logic                fault,
  output logic [2:0]          state
);

  localparam int AW = W + $clog2(SCALE) + 1;
  localparam int DW = $clog2(TON + 1);
  localparam int FW = $clog2(TFLT + 1);
  localparam int HW = $clog2(THIC + 1);
  localparam int RW = $clog2(RETRY + 2);
  localparam int PW = $clog2(TPG + 1);

  localparam logic [AW-1:0] VREF  = AW'(SCALE * VOUT);
  localparam logic [AW-1:0] THR   = AW'(SCALE * VOUT / TSS);
  localparam logic [AW-1:0] DOFF  = AW'(SCALE * VOUT / TOFF);
  localparam logic [AW-1:0] DIV   = AW'(SCALE);
  localparam logic signed [W-1:0] UV_HI   = W'(PIN_MIN + PIN_HYS);
  localparam logic signed [W-1:0] UV_LO   = W'(PIN_MIN);
  localparam logic signed [W-1:0] BIAS_TH = W'(BIAS_MIN);
  localparam logic signed [W-1:0] PG_LIM  = W'(PG_TH);
  localparam logic [W:0]          DROP_V  = (W + 1)'(DROP);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_DELAY = 3'd1,
    S_RAMP  = 3'd2,
    S_ON    = 3'd3,
    S_FALL  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [DW-1:0]        dly_q, dly_d;
  logic [FW-1:0]        flt_q, flt_d;
  logic [HW-1:0]        hic_q, hic_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [PW-1:0]        pg_cnt_q, pg_cnt_d;
  logic                 fault_q, fault_d;
  logic                 uv_ok_q, uv_ok_d;
  logic                 pg_q, pg_d;
  logic signed [W-1:0]  pout_q, pout_d;

  logic                 ok;
  logic                 sc_trip;
  logic [FW-1:0]        flt_next;
  logic [AW:0]          ramp_sum;
  logic [AW-1:0]        ramp_val;
  logic [AW-1:0]        fall_val;
  logic [W:0]           head_raw;
  logic [AW-1:0]        head_ext;
  logic [AW-1:0]        lvl;
  logic                 pg_cond;

  assign ok       = en & (bias > BIAS_TH) & uv_ok_q;
  assign sc_trip  = sc && (flt_q == FW'(TFLT - 1));
  assign flt_next = sc ? flt_q + 1'b1 : '0;
  assign ramp_sum = {1'b0, acc_q} + {1'b0, THR};
  assign ramp_val = (ramp_sum >= {1'b0, VREF}) ? VREF : ramp_sum[AW-1:0];
  assign fall_val = (acc_q >= DOFF) ? acc_q - DOFF : '0;

  // Sequencer next-state: walks the power-up/down sequence and the hiccup fault loop.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dly_d   = dly_q;
    flt_d   = '0;
    hic_d   = hic_q;
    retry_d = retry_q;
    fault_d = fault_q;
    case (state_q)
      S_OFF: begin
        if (ok) begin
          state_d = S_DELAY;
          dly_d   = '0;
        end
      end
      S_DELAY: begin
        if (!ok) state_d = S_FALL;
        else if (dly_q == DW'(TON - 1)) state_d = S_RAMP;
        else dly_d = dly_q + 1'b1;
      end
      S_RAMP, S_ON: begin
        if (!ok) begin
          state_d = S_FALL;
        end else if (sc_trip) begin
          state_d = S_FAULT;
          acc_d   = '0;
          fault_d = 1'b1;
          hic_d   = '0;
          retry_d = (retry_q == RW'(RETRY)) ? retry_q : retry_q + 1'b1;
        end else begin
          flt_d = flt_next;
          if (state_q == S_RAMP) begin
            acc_d = ramp_val;
            if (ramp_val == VREF) begin
              state_d = S_ON;
              retry_d = '0;
            end
          end
        end
      end
      S_FALL: begin
        acc_d = fall_val;
        if (fall_val == '0) state_d = S_OFF;
      end
      S_FAULT: begin
        if (!en) begin
          state_d = S_OFF;
          fault_d = 1'b0;
          retry_d = '0;
          hic_d   = '0;
        end else if (hic_q == HW'(THIC - 1)) begin
          if ((retry_q < RW'(RETRY)) && ok) begin
            state_d = S_DELAY;
            dly_d   = '0;
            fault_d = 1'b0;
          end
        end else begin
          hic_d = hic_q + 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Datapath next values: UVLO hysteresis, clamped output level and power-good qualifier.
  always_comb begin
    uv_ok_d = uv_ok_q;
    if (pin >= UV_HI) uv_ok_d = 1'b1;
    else if (pin < UV_LO) uv_ok_d = 1'b0;

    head_raw = {pin[W-1], pin} - DROP_V;
    head_ext = head_raw[W] ? '0 : AW'(head_raw);
    lvl      = acc_q / DIV;
    pout_d   = '0;
    if (state_d != S_FAULT) pout_d = (lvl < head_ext) ? W'(lvl) : W'(head_ext);

    pg_cond  = (state_q == S_ON) && (pout_q >= PG_LIM);
    pg_cnt_d = '0;
    if (pg_cond) pg_cnt_d = (pg_cnt_q == PW'(TPG)) ? pg_cnt_q : pg_cnt_q + 1'b1;
    pg_d     = pg_cond && (pg_cnt_d == PW'(TPG));
  end

  // State register; reset forces everything off immediately.
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OFF;
      acc_q    <= '0;
      dly_q    <= '0;
      flt_q    <= '0;
      hic_q    <= '0;
      retry_q  <= '0;
      pg_cnt_q <= '0;
      fault_q  <= 1'b0;
      uv_ok_q  <= 1'b0;
      pg_q     <= 1'b0;
      pout_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      dly_q    <= dly_d;
      flt_q    <= flt_d;
      hic_q    <= hic_d;
      retry_q  <= retry_d;
      pg_cnt_q <= pg_cnt_d;
      fault_q  <= fault_d;
      uv_ok_q  <= uv_ok_d;
      pg_q     <= pg_d;
      pout_q   <= pout_d;
    end
  end

  assign pout  = pout_q;
  assign pg    = pg_q;
  assign fault = fault_q;
  assign state = state_q;

endmodule
